// File: rtl/pl_io_pkg.sv
// Shared types and defaults for the PL input conditioning blocks.
// Mode encoding matches the two-bit per-channel cfg_mode field.
package pl_io_pkg;

    typedef enum logic [1:0] {
        COND_LEVEL_E  = 2'b00,
        COND_TOGGLE_E = 2'b01,
        COND_RISE_E   = 2'b10,
        COND_FALL_E   = 2'b11
    } cond_mode_t;

    // 8 ms at 125 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/pl_input_conditioner_ch.sv
// One conditioning channel: synchroniser, counter debouncer, mode output and event flag.
// The event flag is combinational and aligned with the edge that updates stable/cond.
module pl_input_conditioner_ch
    import pl_io_pkg::*;
#(
    parameter int SYNC_STAGES_P     = 2,
    parameter int DEBOUNCE_CYCLES_P = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH_P       = $clog2(DEBOUNCE_CYCLES_P + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw,
    input  cond_mode_t mode,
    output logic       cond,
    output logic       stable,
    output logic       evt
);

    logic [SYNC_STAGES_P-1:0] sync_q;
    logic [CNT_WIDTH_P-1:0]   cnt_q, cnt_d;
    logic                     stable_q, stable_d;
    logic                     toggle_q, toggle_d;
    logic                     cond_q, cond_d;
    cond_mode_t               mode_q;
    logic                     synced, cnt_last, accept, rise, fall, mode_change;

    assign synced      = sync_q[SYNC_STAGES_P-1];
    assign cnt_last    = (cnt_q == CNT_WIDTH_P'(DEBOUNCE_CYCLES_P - 1));
    assign accept      = (synced != stable_q) && cnt_last;
    assign rise        = accept && synced;
    assign fall        = accept && !synced;
    assign mode_change = (mode != mode_q);

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        toggle_d = toggle_q;
        cond_d   = 1'b0;
        evt      = 1'b0;

        // Any matching cycle restarts the count; saturate rather than wrap.
        if (synced == stable_q || accept) begin
            cnt_d = '0;
        end else if (!cnt_last) begin
            cnt_d = cnt_q + CNT_WIDTH_P'(1);
        end
        if (accept) begin
            stable_d = synced;
        end
        if (rise && mode == COND_TOGGLE_E) begin
            toggle_d = !toggle_q;
        end

        // Pulses are suppressed in the cycle the mode switches.
        case (mode)
            COND_LEVEL_E: begin
                cond_d = stable_d;
                evt    = accept;
            end
            COND_TOGGLE_E: begin
                cond_d = toggle_d;
                evt    = rise;
            end
            COND_RISE_E: begin
                cond_d = rise && !mode_change;
                evt    = rise;
            end
            COND_FALL_E: begin
                cond_d = fall && !mode_change;
                evt    = fall;
            end
            default: begin
                cond_d = 1'b0;
                evt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            toggle_q <= 1'b0;
            cond_q   <= 1'b0;
            mode_q   <= COND_LEVEL_E;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES_P-2:0], raw};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            toggle_q <= toggle_d;
            cond_q   <= cond_d;
            mode_q   <= mode;
        end
    end

    assign cond   = cond_q;
    assign stable = stable_q;

endmodule

// File: rtl/pl_input_conditioner.sv
// N-channel conditioner for mechanical PL inputs with optional sticky interrupts.
// Define PL_INPUT_CONDITIONER_IRQ_EN to build irq_status/irq; otherwise both are tied to 0.
module pl_input_conditioner
    import pl_io_pkg::*;
#(
    parameter int NR_OF_CHANNELS_P  = 4,
    parameter int SYNC_STAGES_P     = 2,
    parameter int DEBOUNCE_CYCLES_P = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH_P       = $clog2(DEBOUNCE_CYCLES_P + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NR_OF_CHANNELS_P-1:0]   raw_in,
    input  logic [2*NR_OF_CHANNELS_P-1:0] cfg_mode,
    input  logic [NR_OF_CHANNELS_P-1:0]   irq_mask,
    input  logic [NR_OF_CHANNELS_P-1:0]   irq_clear,
    output logic [NR_OF_CHANNELS_P-1:0]   cond_out,
    output logic [NR_OF_CHANNELS_P-1:0]   stable_out,
    output logic [NR_OF_CHANNELS_P-1:0]   irq_status,
    output logic                          irq
);

    logic [NR_OF_CHANNELS_P-1:0] evt;

    for (genvar i = 0; i < NR_OF_CHANNELS_P; i++) begin : g_ch
        pl_input_conditioner_ch #(
            .SYNC_STAGES_P    (SYNC_STAGES_P),
            .DEBOUNCE_CYCLES_P(DEBOUNCE_CYCLES_P),
            .CNT_WIDTH_P      (CNT_WIDTH_P)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_in[i]),
            .mode  (cond_mode_t'(cfg_mode[2*i +: 2])),
            .cond  (cond_out[i]),
            .stable(stable_out[i]),
            .evt   (evt[i])
        );
    end

`ifdef PL_INPUT_CONDITIONER_IRQ_EN
    logic [NR_OF_CHANNELS_P-1:0] status_q;
    logic                        irq_q;

    // A new event wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= (status_q & ~irq_clear) | evt;
            irq_q    <= |(status_q & irq_mask);
        end
    end

    assign irq_status = status_q;
    assign irq        = irq_q;
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^{irq_mask, irq_clear, evt};
    assign irq_status        = '0;
    assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_pl_input_conditioner.sv
// Directed bench for pl_input_conditioner: vector table plus hand sequences for
// bounce, clear/event collision and mid-count reset.
module tb_pl_input_conditioner;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 16;
    localparam int LAT  = SYNC + DEB;
`ifdef PL_INPUT_CONDITIONER_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   raw_in;
    logic [2*N-1:0] cfg_mode;
    logic [N-1:0]   irq_mask;
    logic [N-1:0]   irq_clear;
    logic [N-1:0]   cond_out;
    logic [N-1:0]   stable_out;
    logic [N-1:0]   irq_status;
    logic           irq;

    int n_checks = 0;
    int n_errors = 0;

    pl_input_conditioner #(
        .NR_OF_CHANNELS_P (N),
        .SYNC_STAGES_P    (SYNC),
        .DEBOUNCE_CYCLES_P(DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_in    (raw_in),
        .cfg_mode  (cfg_mode),
        .irq_mask  (irq_mask),
        .irq_clear (irq_clear),
        .cond_out  (cond_out),
        .stable_out(stable_out),
        .irq_status(irq_status),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] raw;
        logic [N-1:0] mask;
        logic [N-1:0] clr;
        int           n;
        logic [N-1:0] exp_cond;
        logic [N-1:0] exp_stable;
        logic [N-1:0] exp_status;
        logic         exp_irq;
    } vec_t;

    vec_t vecs[23];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [N-1:0] c, input logic [N-1:0] s,
                             input logic [N-1:0] st, input logic q);
        check({name, ".cond"},   32'(cond_out),   32'(c));
        check({name, ".stable"}, 32'(stable_out), 32'(s));
        check({name, ".status"}, 32'(irq_status), 32'(st & {N{IRQ_EN}}));
        check({name, ".irq"},    32'(irq),        32'(q & IRQ_EN));
    endtask

    initial begin
        logic bounce_ok;

        // ch0 LEVEL, ch1 TOGGLE, ch2 RISE, ch3 FALL
        cfg_mode  = 8'b11_10_01_00;
        raw_in    = '0;
        irq_mask  = '0;
        irq_clear = '0;
        rst_n     = 1'b0;

        //            raw      mask     clr      n    cond     stable   status   irq
        vecs[0]  = '{4'b0000, 4'b0001, 4'b0000, 1,   4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[1]  = '{4'b0001, 4'b0001, 4'b0000, 17,  4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[2]  = '{4'b0001, 4'b0001, 4'b0000, 1,   4'b0001, 4'b0001, 4'b0001, 1'b0};
        vecs[3]  = '{4'b0001, 4'b0001, 4'b0000, 1,   4'b0001, 4'b0001, 4'b0001, 1'b1};
        vecs[4]  = '{4'b0011, 4'b0001, 4'b0000, 17,  4'b0001, 4'b0001, 4'b0001, 1'b1};
        vecs[5]  = '{4'b0011, 4'b0001, 4'b0000, 1,   4'b0011, 4'b0011, 4'b0011, 1'b1};
        vecs[6]  = '{4'b0001, 4'b0001, 4'b0000, 18,  4'b0011, 4'b0001, 4'b0011, 1'b1};
        vecs[7]  = '{4'b0011, 4'b0001, 4'b0000, 18,  4'b0001, 4'b0011, 4'b0011, 1'b1};
        vecs[8]  = '{4'b0001, 4'b0001, 4'b0000, 18,  4'b0001, 4'b0001, 4'b0011, 1'b1};
        vecs[9]  = '{4'b0011, 4'b0001, 4'b0000, 18,  4'b0011, 4'b0011, 4'b0011, 1'b1};
        vecs[10] = '{4'b0001, 4'b0001, 4'b0000, 18,  4'b0011, 4'b0001, 4'b0011, 1'b1};
        vecs[11] = '{4'b0101, 4'b0001, 4'b0000, 17,  4'b0011, 4'b0001, 4'b0011, 1'b1};
        vecs[12] = '{4'b0101, 4'b0001, 4'b0000, 1,   4'b0111, 4'b0101, 4'b0111, 1'b1};
        vecs[13] = '{4'b0101, 4'b0001, 4'b0000, 1,   4'b0011, 4'b0101, 4'b0111, 1'b1};
        vecs[14] = '{4'b1101, 4'b0001, 4'b0000, 18,  4'b0011, 4'b1101, 4'b0111, 1'b1};
        vecs[15] = '{4'b0101, 4'b0001, 4'b0000, 17,  4'b0011, 4'b1101, 4'b0111, 1'b1};
        vecs[16] = '{4'b0101, 4'b0001, 4'b0000, 1,   4'b1011, 4'b0101, 4'b1111, 1'b1};
        vecs[17] = '{4'b0101, 4'b0001, 4'b0000, 1,   4'b0011, 4'b0101, 4'b1111, 1'b1};
        vecs[18] = '{4'b0001, 4'b0001, 4'b0000, 18,  4'b0011, 4'b0001, 4'b1111, 1'b1};
        vecs[19] = '{4'b0001, 4'b0001, 4'b1111, 1,   4'b0011, 4'b0001, 4'b0000, 1'b1};
        vecs[20] = '{4'b0001, 4'b0001, 4'b0000, 1,   4'b0011, 4'b0001, 4'b0000, 1'b0};
        vecs[21] = '{4'b0000, 4'b0000, 4'b0000, 18,  4'b0010, 4'b0000, 4'b0001, 1'b0};
        vecs[22] = '{4'b0000, 4'b0000, 4'b0000, 5,   4'b0010, 4'b0000, 4'b0001, 1'b0};

        // Reset state
        repeat (3) step();
        check_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;

        // LEVEL latency, TOGGLE, RISE/FALL, clear and mask via the table
        for (int i = 0; i < 23; i++) begin
            raw_in    = vecs[i].raw;
            irq_mask  = vecs[i].mask;
            irq_clear = vecs[i].clr;
            step();
            irq_clear = '0;
            repeat (vecs[i].n - 1) step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_cond, vecs[i].exp_stable,
                      vecs[i].exp_status, vecs[i].exp_irq);
        end

        // Clear colliding with a new ch0 event: set wins
        irq_clear = 4'b0001;
        irq_mask  = 4'b0001;
        raw_in    = 4'b0001;
        step();
        irq_clear = '0;
        check("clr_pre.status", 32'(irq_status[0]), 32'(0));
        repeat (LAT - 2) step();
        irq_clear = 4'b0001;
        step();
        irq_clear = '0;
        check("clr_evt.stable", 32'(stable_out[0]), 32'(1));
        check("clr_evt.status", 32'(irq_status[0]), 32'(IRQ_EN));
        step();
        check("clr_evt.irq", 32'(irq), 32'(IRQ_EN));
        irq_clear = 4'b0001;
        step();
        irq_clear = '0;
        check("clr_only.status", 32'(irq_status[0]), 32'(0));
        step();
        check("clr_only.irq", 32'(irq), 32'(0));

        // Bounce on ch0: nothing until 18 cycles after the last transition
        raw_in = 4'b0000;
        repeat (LAT) step();
        check("bounce_pre.stable", 32'(stable_out[0]), 32'(0));
        bounce_ok = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (t % 5 == 0) raw_in[0] = ~raw_in[0];
            step();
            if (stable_out[0] !== 1'b0 || cond_out[0] !== 1'b0) bounce_ok = 1'b0;
        end
        check("bounce.quiet", 32'(bounce_ok), 32'(1));
        raw_in[0] = 1'b1;
        repeat (LAT - 1) step();
        check("bounce.early", 32'(stable_out[0]), 32'(0));
        step();
        check("bounce.edge.stable", 32'(stable_out[0]), 32'(1));
        check("bounce.edge.cond", 32'(cond_out[0]), 32'(1));

        // Reset mid-count, raw held high through reset
        raw_in = 4'b0000;
        repeat (LAT) step();
        raw_in = 4'b0001;
        repeat (SYNC + 10) step();
        rst_n = 1'b0;
        #1;
        check_all("rst_mid", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (LAT - 1) step();
        check("rst_rel.early", 32'(stable_out), 32'(0));
        step();
        check_all("rst_rel.edge", 4'b0001, 4'b0001, 4'b0001, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
